// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, state encoding, pc_sel codes and ALU constants for ctrl_sequencer
package ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_STOP   = 3'd6;
  localparam state_t S_FAULT  = 3'd7;
  localparam logic [5:0] OP_ALU  = 6'd0;
  localparam logic [5:0] OP_ALUI = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_ST   = 6'd3;
  localparam logic [5:0] OP_BZ   = 6'd4;
  localparam logic [5:0] OP_J    = 6'd5;
  localparam logic [5:0] OP_HALT = 6'd63;
  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [4:0] ALU_ADD = 5'd0;
  function automatic logic is_legal(input logic [5:0] o);
    return o <= OP_J || o == OP_HALT;
  endfunction
endpackage

// File: rtl/ctrl_timeout_cnt.sv
// ctrl_timeout_cnt: memory-request watchdog; clk, rst_n (sync, active-low), req/ack in, expired out
module ctrl_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  // Clearing on every ack and on every non-request cycle restarts the count on each entry to FETCH/MEM.
  always_ff @(posedge clk) begin
    if (!rst_n || !req || ack) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
  // An ack in the expiry cycle wins.
  assign expired = req && !ack && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM. Inputs clk, rst_n (sync, active-low), run, op, fn, zero, mem_ack; outputs mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src_imm, alu_op, rf_we, rf_wsel, halted, illegal, instret. Optional CTRL_MEM_TIMEOUT_EN adds the watchdog and FAULT state.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [10:0]      fn,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_imm,
  output logic [4:0]       alu_op,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);
  state_t state, next;
  logic [5:0] op_q;
  logic illegal_q, expired, retire;
  logic in_fetch, in_exec, in_mem, in_wb;
  logic is_alu, is_mem_op, is_ctl;
  assign in_fetch  = state == S_FETCH;
  assign in_exec   = state == S_EXEC;
  assign in_mem    = state == S_MEM;
  assign in_wb     = state == S_WB;
  assign is_alu    = op_q == OP_ALU || op_q == OP_ALUI;
  assign is_mem_op = op_q == OP_LD || op_q == OP_ST;
  assign is_ctl    = op_q == OP_BZ || op_q == OP_J;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = run ? S_FETCH : S_IDLE;
      S_FETCH:  next = mem_ack ? S_DECODE : expired ? S_FAULT : S_FETCH;
      S_DECODE: next = S_EXEC;
      S_EXEC:   next = is_alu ? S_WB : is_mem_op ? S_MEM : is_ctl ? S_FETCH : S_STOP;
      S_MEM:    next = mem_ack ? (op_q == OP_LD ? S_WB : S_FETCH) : expired ? S_FAULT : S_MEM;
      S_WB:     next = S_FETCH;
      default:  next = state;
    endcase
  end
  assign mem_req     = in_fetch || in_mem;
  assign mem_we      = in_mem && op_q == OP_ST;
  assign addr_sel    = in_mem;
  assign ir_we       = in_fetch && mem_ack;
  assign pc_we       = ir_we || (in_exec && (op_q == OP_J || (op_q == OP_BZ && zero)));
  assign pc_sel      = !in_exec ? PC_INC : op_q == OP_J ? PC_JMP : op_q == OP_BZ ? PC_BR : PC_INC;
  assign alu_src_imm = (in_exec || in_mem) && (op_q == OP_ALUI || is_mem_op);
  assign alu_op      = in_exec && op_q == OP_ALU ? fn[4:0] : ALU_ADD;
  assign rf_we       = in_wb;
  assign rf_wsel     = in_wb && op_q == OP_LD;
  assign halted      = state == S_STOP || state == S_FAULT;
  assign illegal     = state == S_STOP && illegal_q;
  assign retire      = (in_exec && (is_ctl || op_q == OP_HALT)) || (in_mem && mem_ack && op_q == OP_ST) || in_wb;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_ALU;
      illegal_q <= 1'b0;
      instret   <= '0;
    end else begin
      state <= next;
      if (state == S_DECODE) op_q <= op;
      if (in_exec && !is_legal(op_q)) illegal_q <= 1'b1;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end
`ifdef CTRL_MEM_TIMEOUT_EN
  ctrl_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk),
    .rst_n(rst_n),
    .req(mem_req),
    .ack(mem_ack),
    .expired(expired)
  );
  logic unused_fn;
  assign unused_fn = ^fn[10:5];
`else
  logic unused_cfg;
  assign expired = 1'b0;
  assign unused_cfg = ^{fn[10:5], TIMEOUT_CYCLES};
`endif
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed self-checking bench for ctrl_sequencer (default build)
module tb_ctrl_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, zero = 1'b0, mem_ack = 1'b0;
  logic [5:0] op = '0;
  logic [10:0] fn = '0;
  logic mem_req, mem_we, addr_sel, ir_we, pc_we, alu_src_imm, rf_we, rf_wsel, halted, illegal;
  logic [1:0] pc_sel;
  logic [4:0] alu_op;
  logic [31:0] instret;
  int n_cmp = 0, n_err = 0;
  ctrl_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op(op), .fn(fn), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .halted(halted), .illegal(illegal), .instret(instret)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] outs();
    return 32'({mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src_imm, alu_op, rf_we, rf_wsel, halted, illegal});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("reset_outs", outs(), 32'd0);
    chk("reset_instret", instret, 32'd0);
    rst_n = 1'b1; run = 1'b1; op = 6'd0; fn = 11'd3; mem_ack = 1'b1;
    tick();
    #1 chk("alu_fetch", {mem_req, addr_sel, ir_we, pc_we, pc_sel}, 32'b101100);
    tick();
    #1 chk("alu_decode_req", {mem_req, rf_we}, 32'd0);
    tick();
    #1 chk("alu_exec_op", {alu_op, alu_src_imm}, {26'd0, 5'd3, 1'b0});
    tick();
    #1 chk("alu_wb_c4", {rf_we, rf_wsel}, 32'b10);
    tick();
    mem_ack = 1'b0;
    #1 chk("alu_instret", instret, 32'd1);
    chk("ld_fetch_wait1", {mem_req, addr_sel, ir_we}, 32'b100);
    tick();
    #1 chk("ld_fetch_wait2", {mem_req, addr_sel, ir_we}, 32'b100);
    tick();
    mem_ack = 1'b1; op = 6'd2;
    #1 chk("ld_fetch_ack", {mem_req, ir_we, pc_we}, 32'b111);
    tick();
    #1 chk("ld_decode_ack_ignored", {ir_we, pc_we, mem_req}, 32'd0);
    tick();
    mem_ack = 1'b0; op = 6'd0;
    #1 chk("ld_exec", {alu_src_imm, alu_op, mem_req}, {26'd0, 1'b1, 5'd0, 1'b0});
    tick();
    #1 chk("ld_mem_wait1", {mem_req, addr_sel, mem_we, alu_src_imm}, 32'b1101);
    tick();
    #1 chk("ld_mem_wait2", {mem_req, addr_sel, mem_we}, 32'b110);
    tick();
    mem_ack = 1'b1;
    #1 chk("ld_mem_ack", {mem_req, addr_sel, rf_we}, 32'b110);
    tick();
    #1 chk("ld_wb_c9", {rf_we, rf_wsel, mem_req}, 32'b110);
    tick();
    op = 6'd4; zero = 1'b1;
    #1 chk("ld_instret", instret, 32'd2);
    tick();
    tick();
    #1 chk("bz_taken", {pc_we, pc_sel}, 32'b101);
    tick();
    zero = 1'b0;
    #1 chk("bz1_instret", instret, 32'd3);
    tick();
    tick();
    #1 chk("bz_not_taken", pc_we, 32'd0);
    tick();
    op = 6'd5;
    #1 chk("bz0_instret", instret, 32'd4);
    tick();
    tick();
    #1 chk("j_exec", {pc_we, pc_sel}, 32'b110);
    tick();
    op = 6'd3;
    #1 chk("j_instret", instret, 32'd5);
    tick();
    tick();
    #1 chk("st_exec", {alu_src_imm, mem_req}, 32'b10);
    tick();
    #1 chk("st_mem", {mem_req, mem_we, addr_sel, alu_src_imm}, 32'b1111);
    tick();
    op = 6'd17;
    #1 chk("st_instret", instret, 32'd6);
    tick();
    tick();
    tick();
    op = 6'd0;
    #1 chk("illegal_stop", {halted, illegal, mem_req}, 32'b110);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    tick();
    #1 chk("illegal_hold", {halted, illegal, mem_req, rf_we}, 32'b1100);
    chk("illegal_instret", instret, 32'd6);
    rst_n = 1'b0;
    tick();
    #1 chk("stop_reset_outs", outs(), 32'd0);
    chk("stop_reset_instret", instret, 32'd0);
    rst_n = 1'b1; op = 6'd2; mem_ack = 1'b1;
    tick();
    tick();
    tick();
    mem_ack = 1'b0;
    tick();
    #1 chk("mid_mem_req", {mem_req, addr_sel}, 32'b11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; run = 1'b0; mem_ack = 1'b1;
    #1 chk("mid_reset_outs", outs(), 32'd0);
    chk("mid_reset_instret", instret, 32'd0);
    tick();
    tick();
    #1 chk("late_ack_no_write", {rf_we, mem_req, ir_we}, 32'd0);
    chk("late_ack_instret", instret, 32'd0);
    run = 1'b1; op = 6'd63;
    tick();
    tick();
    tick();
    tick();
    #1 chk("halt_stop", {halted, illegal}, 32'b10);
    chk("halt_instret", instret, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
